// File: rtl/hdmi_period_scheduler.sv
// Raster timing and TMDS period sequencer for the HDMI transmit path (pixclk domain).
// Every output is registered and describes the coordinate shown on counter_x/counter_y.
module hdmi_period_scheduler_chk #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int CW       = 12
) (
    input logic pixclk
);
    // Parameter sanity: preamble must not overlap hSync and counters must fit.
    always @(posedge pixclk) begin
        assert (H_TOTAL - 10 >= H_ACTIVE + H_FP + H_SYNC)
            else $error("hdmi_period_scheduler: preamble overlaps hsync");
        assert ((H_TOTAL < 2 ** CW) && (V_TOTAL < 2 ** CW))
            else $error("hdmi_period_scheduler: totals exceed coordinate width");
    end
endmodule

module hdmi_period_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_TOTAL  = 525,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int CW       = 12
) (
    input  logic          pixclk,
    input  logic          reset,
    input  logic          en,
    input  logic          pix_valid,
    input  logic          underflow_clr,
    output logic [CW-1:0] counter_x,
    output logic [CW-1:0] counter_y,
    output logic          hsync,
    output logic          vsync,
    output logic [1:0]    period,
    output logic [3:0]    ctl,
    output logic          pix_req,
    output logic          frame_start,
    output logic          video_on,
    output logic          underflow
);

    localparam logic [CW-1:0] X_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_PRE      = CW'(H_TOTAL - 10);
    localparam logic [CW-1:0] X_GUARD    = CW'(H_TOTAL - 2);
    localparam logic [CW-1:0] X_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] X_ACT_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] ZERO       = {CW{1'b0}};
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic          HS_ON      = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic          VS_ON      = (VS_POL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        P_CONTROL  = 2'b00,
        P_PREAMBLE = 2'b01,
        P_GUARD    = 2'b10,
        P_VIDEO    = 2'b11
    } period_e;

    logic [CW-1:0] x_q, x_d, y_q, y_d, y_next_line;
    logic          run_q, run_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    period_e       state_q, state_d;
    logic [3:0]    ctl_q, ctl_d;
    logic          pix_req_q, pix_req_d;
    logic          frame_start_q, frame_start_d;
    logic          video_on_q, video_on_d;
    logic          underflow_q, underflow_d;
    logic          next_line_active;

    hdmi_period_scheduler_chk #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .CW       (CW)
    ) u_chk (
        .pixclk (pixclk)
    );

    // Coordinate advance; the first cycle after reset presents the origin.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        run_d = 1'b1;
        if (!run_q) begin
            x_d = ZERO;
            y_d = ZERO;
        end else if (x_q == X_LAST) begin
            x_d = ZERO;
            y_d = (y_q == Y_LAST) ? ZERO : (y_q + ONE);
        end else begin
            x_d = x_q + ONE;
        end
    end

    // Syncs, frame marker, frame-boundary enable latch and sticky underflow.
    always_comb begin
        hsync_d       = ((x_d >= HS_START) && (x_d < HS_END)) ? HS_ON : ~HS_ON;
        vsync_d       = ((y_d >= VS_START) && (y_d < VS_END)) ? VS_ON : ~VS_ON;
        frame_start_d = (x_d == ZERO) && (y_d == ZERO);
        video_on_d    = video_on_q;
        if ((x_d == ZERO) && (y_d == Y_ACT)) begin
            video_on_d = en;
        end else begin
            video_on_d = video_on_q;
        end
        // Set has priority over clear when both land in the same cycle.
        underflow_d = underflow_q;
        if ((state_q == P_VIDEO) && !pix_valid) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Period sequencing: the lead-in for a line is issued at the end of the previous one.
    always_comb begin
        y_next_line      = (y_d == Y_LAST) ? ZERO : (y_d + ONE);
        next_line_active = (y_next_line < Y_ACT);
        state_d          = state_q;
        if (!video_on_d) begin
            state_d = P_CONTROL;
        end else begin
            case (state_q)
                P_CONTROL: begin
                    if (next_line_active && (x_d == X_PRE)) state_d = P_PREAMBLE;
                    else                                    state_d = P_CONTROL;
                end
                P_PREAMBLE: begin
                    if (x_d == X_GUARD) state_d = P_GUARD;
                    else                state_d = P_PREAMBLE;
                end
                P_GUARD: begin
                    if (x_d == ZERO) state_d = P_VIDEO;
                    else             state_d = P_GUARD;
                end
                P_VIDEO: begin
                    if (x_d == X_ACT) state_d = P_CONTROL;
                    else              state_d = P_VIDEO;
                end
                default: state_d = P_CONTROL;
            endcase
        end
        ctl_d     = (state_d == P_PREAMBLE) ? 4'b0001 : 4'b0000;
        // Request leads each video cycle by one: last guard cycle plus all but the last pixel.
        pix_req_d = ((state_d == P_GUARD) && (x_d == X_LAST)) ||
                    ((state_d == P_VIDEO) && (x_d < X_ACT_LAST));
    end

    // State and output registers.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            x_q           <= ZERO;
            y_q           <= ZERO;
            run_q         <= 1'b0;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            state_q       <= P_CONTROL;
            ctl_q         <= 4'b0000;
            pix_req_q     <= 1'b0;
            frame_start_q <= 1'b0;
            video_on_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            run_q         <= run_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            state_q       <= state_d;
            ctl_q         <= ctl_d;
            pix_req_q     <= pix_req_d;
            frame_start_q <= frame_start_d;
            video_on_q    <= video_on_d;
            underflow_q   <= underflow_d;
        end
    end

    assign counter_x   = x_q;
    assign counter_y   = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign period      = state_q;
    assign ctl         = ctl_q;
    assign pix_req     = pix_req_q;
    assign frame_start = frame_start_q;
    assign video_on    = video_on_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Scoreboard bench for hdmi_period_scheduler with a shrunken raster so many frames fit.
module tb_hdmi_period_scheduler;

    localparam int HA = 16, HF = 2, HS = 4, HT = 32;
    localparam int VA = 6, VF = 1, VS = 2, VT = 10;
    localparam int CW = 12;
    localparam int FR = HT * VT;
    localparam logic HS_ON = 1'b1;
    localparam logic VS_ON = 1'b0;

    logic          clk = 1'b0;
    logic          reset = 1'b1, en = 1'b0, pix_valid = 1'b1, underflow_clr = 1'b0;
    logic [CW-1:0] counter_x, counter_y;
    logic          hsync, vsync, pix_req, frame_start, video_on, underflow;
    logic [1:0]    period;
    logic [3:0]    ctl;

    hdmi_period_scheduler #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_TOTAL (HT),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_TOTAL (VT),
        .HS_POL (1), .VS_POL (0), .CW (CW)
    ) dut (
        .pixclk        (clk),
        .reset         (reset),
        .en            (en),
        .pix_valid     (pix_valid),
        .underflow_clr (underflow_clr),
        .counter_x     (counter_x),
        .counter_y     (counter_y),
        .hsync         (hsync),
        .vsync         (vsync),
        .period        (period),
        .ctl           (ctl),
        .pix_req       (pix_req),
        .frame_start   (frame_start),
        .video_on      (video_on),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          hs;
        logic          vs;
        logic [1:0]    per;
        logic [3:0]    ctl;
        logic          preq;
        logic          fs;
        logic          vo;
        logic          uf;
    } obs_t;

    obs_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_t      = -1;
    logic       m_vo     = 1'b0;
    logic       m_uf     = 1'b0;
    logic [1:0] m_per    = 2'b00;

    // Period from raster rules: video on active pixels, lead-in at the tail of the line before.
    function automatic logic [1:0] period_at(input int t, input logic vo);
        int x, y, nl;
        x  = t % HT;
        y  = (t / HT) % VT;
        nl = (y + 1) % VT;
        if (!vo) return 2'b00;
        if (y < VA && x < HA) return 2'b11;
        if (nl < VA && x >= HT - 10) return (x <= HT - 3) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic int next_x();
        return (m_t + 1) % HT;
    endfunction

    function automatic int next_y();
        return ((m_t + 1) / HT) % VT;
    endfunction

    task automatic step(input logic r, input logic e, input logic pv, input logic clr);
        obs_t o;
        int   x, y;
        @(negedge clk);
        reset = r; en = e; pix_valid = pv; underflow_clr = clr;
        if (r) begin
            m_t = -1; m_vo = 1'b0; m_uf = 1'b0; m_per = 2'b00;
            o = '{x: '0, y: '0, hs: ~HS_ON, vs: ~VS_ON, per: 2'b00, ctl: 4'b0000,
                  preq: 1'b0, fs: 1'b0, vo: 1'b0, uf: 1'b0};
        end else begin
            m_t = m_t + 1;
            x = m_t % HT;
            y = (m_t / HT) % VT;
            if (x == 0 && y == VA) m_vo = e;
            m_uf  = (m_per == 2'b11 && !pv) ? 1'b1 : (clr ? 1'b0 : m_uf);
            m_per = period_at(m_t, m_vo);
            o.x    = CW'(x);
            o.y    = CW'(y);
            o.hs   = (x >= HA + HF && x < HA + HF + HS) ? HS_ON : ~HS_ON;
            o.vs   = (y >= VA + VF && y < VA + VF + VS) ? VS_ON : ~VS_ON;
            o.per  = m_per;
            o.ctl  = (m_per == 2'b01) ? 4'b0001 : 4'b0000;
            o.preq = (period_at(m_t + 1, m_vo) == 2'b11);
            o.fs   = (x == 0 && y == 0);
            o.vo   = m_vo;
            o.uf   = m_uf;
        end
        exp_q.push_back(o);
    endtask

    // Monitor: one DUT observation per cycle, compared against the oldest expectation.
    initial begin
        obs_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{x: counter_x, y: counter_y, hs: hsync, vs: vsync, per: period, ctl: ctl,
                      preq: pix_req, fs: frame_start, vo: video_on, uf: underflow};
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL obs @%0t actual x=%0d y=%0d hs=%b vs=%b per=%b ctl=%b preq=%b fs=%b vo=%b uf=%b required x=%0d y=%0d hs=%b vs=%b per=%b ctl=%b preq=%b fs=%b vo=%b uf=%b",
                              $time, a.x, a.y, a.hs, a.vs, a.per, a.ctl, a.preq, a.fs, a.vo, a.uf,
                              e.x, e.y, e.hs, e.vs, e.per, e.ctl, e.preq, e.fs, e.vo, e.uf);
            end
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
        // Enable held from reset: video begins the frame after the first latch point.
        repeat (3 * FR) step(1'b0, 1'b1, 1'b1, 1'b0);
        // Drop enable mid-picture, then restore it.
        while (next_y() != 2) step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2 * FR) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3 * FR) step(1'b0, 1'b1, 1'b1, 1'b0);
        // Random pixel starvation and clears.
        repeat (2 * FR) step(1'b0, 1'b1, ($urandom_range(0, 15) != 0), ($urandom_range(0, 5) == 0));
        // Reset in the middle of an active line.
        while (!(next_x() == HA / 2 && next_y() == 3)) step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2 * FR) step(1'b0, 1'b1, 1'b1, 1'b0);
        // Fully random inputs.
        repeat (4 * FR) step(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) != 0),
                             ($urandom_range(0, 4) == 0));
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
